// File: rtl/fir_filter_param_pkg.sv
// fir_pkg: shared width derivation, rounding constant and signed saturation helpers for the FIR
package fir_pkg;
  function automatic int clog2_taps(input int taps);
    return $clog2(taps);
  endfunction
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction
  function automatic logic signed [63:0] round_const(input int shift);
    return shift == 0 ? 64'sd0 : 64'sd1 <<< (shift - 1);
  endfunction
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/fir_filter_param_if.sv
// fir_filter_param_if: coefficient-write, sample-in and result-out signals of the FIR
//  master: drives coef_we/coef_addr/coef_data/in_valid/in_data, receives out_valid/out_data/out_sat
//  slave : the filter side
interface fir_filter_param_if #(parameter int AW = 4, DATA_W = 8, COEF_W = 8, OUT_W = 16);
  logic coef_we;
  logic [AW-1:0] coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic out_valid;
  logic signed [OUT_W-1:0] out_data;
  logic out_sat;
  modport master(output coef_we, coef_addr, coef_data, in_valid, in_data,
                 input out_valid, out_data, out_sat);
  modport slave(input coef_we, coef_addr, coef_data, in_valid, in_data,
                output out_valid, out_data, out_sat);
endinterface

// File: rtl/fir_round_sat.sv
// fir_round_sat: registered round-half-up, arithmetic shift and signed saturation of the FIR sum
//  clock/reset: rising edge, synchronous active-high
//  in_valid/sum: full-precision sum and its qualifier
//  out_valid/out_data/out_sat: result pulse, clipped value, clip flag (held while out_valid=0)
module fir_round_sat import fir_pkg::*; #(
  parameter int ACC_W = 20,
  parameter int SHIFT = 0,
  parameter int OUT_W = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic in_valid,
  input  logic signed [ACC_W-1:0] sum,
  output logic out_valid,
  output logic signed [OUT_W-1:0] out_data,
  output logic out_sat
);
  logic signed [ACC_W:0] rnd, s;
  logic signed [63:0] c;
  // one extra bit so adding the half-LSB constant cannot wrap
  always_comb begin
    rnd = (ACC_W+1)'(sum) + (ACC_W+1)'(round_const(SHIFT));
    s = rnd >>> SHIFT;
    c = sat_signed(64'(s), OUT_W);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sat <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= OUT_W'(c);
        out_sat <= c != 64'(s);
      end
    end
  end
endmodule

// File: rtl/fir_filter_param.sv
// fir_filter_param: signed direct-form FIR with run-time loadable coefficients and round/shift/saturate output
//  clock/reset: rising edge, synchronous active-high
//  bus (slave): coef_we/coef_addr/coef_data write port, in_valid/in_data samples,
//               out_valid/out_data/out_sat results three register stages after each sample
module fir_filter_param import fir_pkg::*; #(
  parameter int TAPS   = 10,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input logic clock,
  input logic reset,
  fir_filter_param_if.slave bus
);
  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
  localparam int AW = clog2_taps(TAPS);
  localparam int PW = DATA_W + COEF_W;
  logic signed [DATA_W-1:0] x [TAPS-1];
  logic signed [DATA_W-1:0] tap [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [PW-1:0] p [TAPS];
  logic signed [ACC_W-1:0] sum, acc;
  logic [AW-1:0] wa;
  logic v1, v2;
  assign wa = bus.coef_addr;
  // tap 0 is the arriving sample; the rest read the delay line before it shifts
  assign tap[0] = bus.in_data;
  for (genvar k = 1; k < TAPS; k++) begin : g_tap
    assign tap[k] = x[k-1];
  end
  always_comb begin
    acc = '0;
    for (int k = 0; k < TAPS; k++) acc = acc + ACC_W'(p[k]);
  end
  // coefficient writes land with the products' nonblocking update, so a same-cycle sample sees the old value
  always_ff @(posedge clock) begin
    if (reset) begin
      x <= '{default: '0};
      coef <= '{default: '0};
      p <= '{default: '0};
      sum <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= bus.in_valid;
      v2 <= v1;
      if (v1) sum <= acc;
      if (bus.coef_we && 32'(wa) < TAPS) coef[wa] <= bus.coef_data;
      if (bus.in_valid) begin
        x[0] <= bus.in_data;
        for (int k = 1; k < TAPS - 1; k++) x[k] <= x[k-1];
        for (int k = 0; k < TAPS; k++) p[k] <= PW'(coef[k]) * PW'(tap[k]);
      end
    end
  end
  fir_round_sat #(.ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_round_sat (
    .clock(clock),
    .reset(reset),
    .in_valid(v2),
    .sum(sum),
    .out_valid(bus.out_valid),
    .out_data(bus.out_data),
    .out_sat(bus.out_sat)
  );
endmodule

// File: tb/tb_fir_filter_param.sv
// tb_fir_filter_param: directed checks of three FIR variants (default, OUT_W=8, SHIFT=2) against a sum-of-products model
module tb_fir_filter_param;
  logic clock = 1'b0;
  logic reset;
  logic coef_we, in_valid;
  logic [3:0] coef_addr;
  logic signed [7:0] coef_data, in_data;
  int cyc = 0, checks = 0, errors = 0;
  always #5 clock = ~clock;

  fir_filter_param_if #(.AW(4), .DATA_W(8), .COEF_W(8), .OUT_W(16)) ia();
  fir_filter_param_if #(.AW(4), .DATA_W(8), .COEF_W(8), .OUT_W(8)) ib();
  fir_filter_param_if #(.AW(4), .DATA_W(8), .COEF_W(8), .OUT_W(16)) ic();
  fir_filter_param #(.OUT_W(16), .SHIFT(0)) dut_a(.clock(clock), .reset(reset), .bus(ia.slave));
  fir_filter_param #(.OUT_W(8), .SHIFT(0)) dut_b(.clock(clock), .reset(reset), .bus(ib.slave));
  fir_filter_param #(.OUT_W(16), .SHIFT(2)) dut_c(.clock(clock), .reset(reset), .bus(ic.slave));
  assign ia.coef_we = coef_we;
  assign ia.coef_addr = coef_addr;
  assign ia.coef_data = coef_data;
  assign ia.in_valid = in_valid;
  assign ia.in_data = in_data;
  assign ib.coef_we = coef_we;
  assign ib.coef_addr = coef_addr;
  assign ib.coef_data = coef_data;
  assign ib.in_valid = in_valid;
  assign ib.in_data = in_data;
  assign ic.coef_we = coef_we;
  assign ic.coef_addr = coef_addr;
  assign ic.coef_data = coef_data;
  assign ic.in_valid = in_valid;
  assign ic.in_data = in_data;

  typedef struct {int due; longint sum;} ex_t;
  typedef struct {int dut; int d; bit s; int c;} ob_t;
  ex_t exp_q[$];
  ob_t obs[$];
  int shf[3] = '{0, 0, 2};
  int ow[3] = '{16, 8, 16};
  int ld[3], mcoef[10], hist[9];
  bit ls[3];

  // y = sat(floor((sum + half) / 2^sh)), written as plain integer division
  function automatic void rs(input longint s, input int sh, input int w, output int d, output bit sat);
    longint q, dv, lim;
    dv = longint'(1) << sh;
    q = sh == 0 ? s : s + dv / 2;
    q = q >= 0 ? q / dv : -((-q + dv - 1) / dv);
    lim = longint'(1) << (w - 1);
    sat = q > lim - 1 || q < -lim;
    d = int'(q > lim - 1 ? lim - 1 : q < -lim ? -lim : q);
  endfunction

  always @(posedge clock) begin
    longint s;
    cyc++;
    if (reset) begin
      mcoef = '{default: 0};
      hist = '{default: 0};
      exp_q.delete();
      ld = '{default: 0};
      ls = '{default: 0};
    end else begin
      if (in_valid) begin
        s = longint'(mcoef[0]) * int'(in_data);
        for (int k = 1; k < 10; k++) s += longint'(mcoef[k]) * hist[k-1];
        exp_q.push_back('{cyc + 2, s});
        for (int k = 8; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = int'(in_data);
      end
      if (coef_we && int'(coef_addr) < 10) mcoef[coef_addr] = int'(coef_data);
    end
  end

  always @(negedge clock) if (cyc > 0) begin
    bit ev, a_v, a_s;
    int a_d;
    longint es;
    ev = exp_q.size() > 0 && exp_q[0].due == cyc;
    es = ev ? exp_q[0].sum : 0;
    for (int i = 0; i < 3; i++) begin
      if (ev) rs(es, shf[i], ow[i], ld[i], ls[i]);
      a_v = i == 0 ? ia.out_valid : i == 1 ? ib.out_valid : ic.out_valid;
      a_s = i == 0 ? ia.out_sat : i == 1 ? ib.out_sat : ic.out_sat;
      a_d = i == 0 ? int'(ia.out_data) : i == 1 ? int'(ib.out_data) : int'(ic.out_data);
      checks++;
      if (a_v !== ev || a_d != ld[i] || a_s !== ls[i]) begin
        errors++;
        $display("FAIL out dut%0d cyc=%0d: got v=%0b d=%0d s=%0b, want v=%0b d=%0d s=%0b",
                 i, cyc, a_v, a_d, a_s, ev, ld[i], ls[i]);
      end
      if (a_v) obs.push_back('{i, a_d, a_s, cyc + 1});
    end
    if (ev) void'(exp_q.pop_front());
  end

  function automatic int find(input int dut, input int idx);
    int n = 0;
    foreach (obs[j]) if (obs[j].dut == dut) begin
      if (n == idx) return j;
      n++;
    end
    return -1;
  endfunction

  function automatic int cnt(input int dut);
    int n = 0;
    foreach (obs[j]) if (obs[j].dut == dut) n++;
    return n;
  endfunction

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, want);
    end
  endtask

  task automatic chk_obs(input string nm, input int dut, input int idx, input int d, input bit s);
    int j = find(dut, idx);
    checks++;
    if (j < 0) begin
      errors++;
      $display("FAIL %s: dut%0d output #%0d missing, want d=%0d s=%0b", nm, dut, idx, d, s);
    end else if (obs[j].d != d || obs[j].s != s) begin
      errors++;
      $display("FAIL %s: dut%0d output #%0d got d=%0d s=%0b, want d=%0d s=%0b",
               nm, dut, idx, obs[j].d, obs[j].s, d, s);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    coef_we = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic sample(input int v);
    in_valid = 1'b1;
    in_data = 8'(v);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wcoef(input int a, input int v);
    coef_we = 1'b1;
    coef_addr = 4'(a);
    coef_data = 8'(v);
    @(negedge clock);
    coef_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    obs.delete();
  endtask

  initial begin
    int d, imp;
    bit s;
    int c1[10] = '{7, 8, 9, 12, 4, 6, 3, 2, 5, -42};
    int rv[6] = '{6, -6, 5, -5, 2, -2};
    reset = 1'b1;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    in_valid = 1'b0;
    in_data = '0;
    rs(6, 2, 16, d, s);
    chk("model round 6>>2", d, 2);
    rs(-6, 2, 16, d, s);
    chk("model round -6>>2", d, -1);
    rs(161290, 0, 8, d, s);
    chk("model sat hi", d, 127);
    chk("model sat hi flag", int'(s), 1);
    rs(-162560, 0, 8, d, s);
    chk("model sat lo", d, -128);
    do_reset();
    chk("reset out_data", int'(ia.out_data), 0);
    chk("reset out_sat", int'(ia.out_sat), 0);
    // impulse
    for (int k = 0; k < 10; k++) wcoef(k, c1[k]);
    imp = cyc + 1;
    sample(1);
    repeat (9) sample(0);
    idle(5);
    for (int k = 0; k < 10; k++) chk_obs("impulse", 0, k, c1[k], 1'b0);
    d = find(0, 0);
    chk("impulse latency", d < 0 ? -1 : obs[d].c - imp, 3);
    chk_obs("impulse shift2", 2, 9, -10, 1'b0);
    // step with gaps
    do_reset();
    for (int k = 0; k < 10; k++) wcoef(k, 1);
    for (int n = 0; n < 12; n++) begin
      sample(3);
      idle(2);
    end
    idle(4);
    for (int n = 0; n < 12; n++) chk_obs("step", 0, n, 3 * (n < 10 ? n + 1 : 10), 1'b0);
    // saturation
    do_reset();
    for (int k = 0; k < 10; k++) wcoef(k, 127);
    repeat (10) sample(127);
    repeat (10) sample(-128);
    idle(5);
    chk_obs("sat first", 1, 0, 127, 1'b1);
    chk_obs("sat hi", 1, 9, 127, 1'b1);
    chk_obs("sat lo", 1, 19, -128, 1'b1);
    chk_obs("sat wide", 0, 9, 32767, 1'b1);
    // round/shift
    do_reset();
    wcoef(0, 1);
    foreach (rv[i]) sample(rv[i]);
    idle(5);
    chk_obs("round 6", 2, 0, 2, 1'b0);
    chk_obs("round -6", 2, 1, -1, 1'b0);
    chk_obs("round noshift", 0, 0, 6, 1'b0);
    // coefficient update timing
    do_reset();
    wcoef(0, 1);
    in_valid = 1'b1;
    in_data = 8'sd2;
    coef_we = 1'b1;
    coef_addr = 4'd0;
    coef_data = 8'sd5;
    @(negedge clock);
    idle(0);
    sample(2);
    wcoef(10, 99);
    wcoef(15, 99);
    sample(2);
    idle(5);
    chk_obs("coef same cycle", 0, 0, 2, 1'b0);
    chk_obs("coef next", 0, 1, 10, 1'b0);
    chk_obs("coef addr oob", 0, 2, 10, 1'b0);
    // reset mid-stream
    do_reset();
    wcoef(0, 1);
    sample(1);
    sample(1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    obs.delete();
    idle(6);
    chk("no stale pulses", cnt(0), 0);
    sample(1);
    idle(5);
    chk_obs("coef cleared", 0, 0, 0, 1'b0);
    chk("one pulse", cnt(0), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
